// File: rtl/chirp_sweep.sv
// rtl/chirp_sweep.sv - linear-FM sweep controller driving NCO control word and NCO reset
module chirp_sweep #(
    parameter int W  = 32,
    parameter int RW = 32,
    parameter int GW = 8,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  min_ctrl,
    input  logic [W-1:0]  max_ctrl,
    input  logic [W-1:0]  step,
    input  logic [RW-1:0] div_rate,
    input  logic [GW-1:0] gap,
    input  logic [NW-1:0] count,
    output logic [W-1:0]  nco_ctrl,
    output logic          nco_reset,
    output logic          busy,
    output logic          sweep_start,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    // State, captured configuration and registered outputs
    state_t        state_q,       state_d;
    logic [1:0]    mode_q,        mode_d;
    logic [W-1:0]  min_q,         min_d;
    logic [W-1:0]  max_q,         max_d;
    logic [W-1:0]  step_q,        step_d;
    logic [RW-1:0] div_q,         div_d;
    logic [GW-1:0] gap_q,         gap_d;
    logic [NW-1:0] count_q,       count_d;
    logic [RW-1:0] rate_q,        rate_d;
    logic [GW-1:0] gap_cnt_q,     gap_cnt_d;
    logic [NW-1:0] sweep_cnt_q,   sweep_cnt_d;
    logic          down_q,        down_d;
    logic [W-1:0]  nco_q,         nco_d;
    logic          nco_reset_q,   nco_reset_d;
    logic          busy_q,        busy_d;
    logic          sweep_start_q, sweep_start_d;
    logic          done_q,        done_d;
    logic          err_q,         err_d;

    // Datapath helpers derived from the captured configuration
    logic [W-1:0]  start_val;
    logic          start_down;
    logic [W:0]    up_sum;
    logic [W-1:0]  up_next;
    logic [W-1:0]  down_room;
    logic [W-1:0]  down_next;
    logic [W-1:0]  tri_turn;
    logic          tick;
    logic          seg_end;
    logic [NW-1:0] sweep_cnt_inc;
    logic          last_sweep;
    logic [W-1:0]  step_in;
    logic [W-1:0]  start_val_in;

    // Next-value arithmetic: one extra bit on the way up, room check on the way down, so stepping clamps instead of wrapping
    always_comb begin
        start_down    = (mode_q == MODE_DOWN);
        start_val     = start_down ? max_q : min_q;
        up_sum        = {1'b0, nco_q} + {1'b0, step_q};
        up_next       = (up_sum > {1'b0, max_q}) ? max_q : up_sum[W-1:0];
        down_room     = nco_q - min_q;
        down_next     = (down_room > step_q) ? (nco_q - step_q) : min_q;
        tri_turn      = ((max_q - min_q) > step_q) ? (max_q - step_q) : min_q;
        tick          = (rate_q == div_q);
        seg_end       = down_q ? (nco_q == min_q) : (nco_q == max_q);
        sweep_cnt_inc = sweep_cnt_q + NW'(1);
        last_sweep    = (count_q != '0) && (sweep_cnt_inc == count_q);
        step_in       = (step == '0) ? W'(1) : step;
        start_val_in  = (mode == MODE_DOWN) ? max_ctrl : min_ctrl;
    end

    // Next-state logic for the IDLE/SWEEP/GAP controller; pulses default low every cycle
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        min_d         = min_q;
        max_d         = max_q;
        step_d        = step_q;
        div_d         = div_q;
        gap_d         = gap_q;
        count_d       = count_q;
        rate_d        = rate_q;
        gap_cnt_d     = gap_cnt_q;
        sweep_cnt_d   = sweep_cnt_q;
        down_d        = down_q;
        nco_d         = nco_q;
        nco_reset_d   = nco_reset_q;
        busy_d        = busy_q;
        sweep_start_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start together with stop is deliberately ignored
                if (start && !stop) begin
                    if (min_ctrl > max_ctrl) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d        = mode;
                        min_d         = min_ctrl;
                        max_d         = max_ctrl;
                        step_d        = step_in;
                        div_d         = div_rate;
                        gap_d         = gap;
                        count_d       = count;
                        rate_d        = '0;
                        gap_cnt_d     = '0;
                        sweep_cnt_d   = '0;
                        down_d        = (mode == MODE_DOWN);
                        nco_d         = start_val_in;
                        nco_reset_d   = 1'b0;
                        busy_d        = 1'b1;
                        sweep_start_d = 1'b1;
                        state_d       = S_SWEEP;
                    end
                end
            end

            S_SWEEP: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    nco_d       = '0;
                    nco_reset_d = 1'b1;
                    busy_d      = 1'b0;
                    rate_d      = '0;
                    gap_cnt_d   = '0;
                end else if (!tick) begin
                    rate_d = rate_q + RW'(1);
                end else begin
                    rate_d = '0;
                    if (!seg_end) begin
                        nco_d = down_q ? down_next : up_next;
                    end else if ((mode_q == MODE_TRI) && !down_q) begin
                        // Turnaround takes its first downward step on the same tick
                        down_d = 1'b1;
                        nco_d  = tri_turn;
                    end else begin
                        sweep_cnt_d = sweep_cnt_inc;
                        if (last_sweep) begin
                            state_d     = S_IDLE;
                            nco_d       = '0;
                            nco_reset_d = 1'b1;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else if (gap_q == '0) begin
                            down_d        = start_down;
                            nco_d         = start_val;
                            sweep_start_d = 1'b1;
                        end else begin
                            state_d     = S_GAP;
                            gap_cnt_d   = '0;
                            down_d      = start_down;
                            nco_d       = start_val;
                            nco_reset_d = 1'b1;
                        end
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    nco_d       = '0;
                    nco_reset_d = 1'b1;
                    busy_d      = 1'b0;
                    rate_d      = '0;
                    gap_cnt_d   = '0;
                end else if (gap_cnt_q == (gap_q - GW'(1))) begin
                    // Entering GAP counts as the first gap cycle, so leave after gap_q cycles in total
                    state_d       = S_SWEEP;
                    gap_cnt_d     = '0;
                    rate_d        = '0;
                    nco_d         = start_val;
                    nco_reset_d   = 1'b0;
                    sweep_start_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d     = S_IDLE;
                nco_d       = '0;
                nco_reset_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Register all state and outputs; reset is asynchronous so the NCO is held immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            min_q         <= '0;
            max_q         <= '0;
            step_q        <= '0;
            div_q         <= '0;
            gap_q         <= '0;
            count_q       <= '0;
            rate_q        <= '0;
            gap_cnt_q     <= '0;
            sweep_cnt_q   <= '0;
            down_q        <= 1'b0;
            nco_q         <= '0;
            nco_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            sweep_start_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            min_q         <= min_d;
            max_q         <= max_d;
            step_q        <= step_d;
            div_q         <= div_d;
            gap_q         <= gap_d;
            count_q       <= count_d;
            rate_q        <= rate_d;
            gap_cnt_q     <= gap_cnt_d;
            sweep_cnt_q   <= sweep_cnt_d;
            down_q        <= down_d;
            nco_q         <= nco_d;
            nco_reset_q   <= nco_reset_d;
            busy_q        <= busy_d;
            sweep_start_q <= sweep_start_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign nco_ctrl    = nco_q;
    assign nco_reset   = nco_reset_q;
    assign busy        = busy_q;
    assign sweep_start = sweep_start_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/chirp_sweep.md
# chirp_sweep

Parametrised linear-FM sweep controller driving the NCO frequency control word and NCO reset in the waveform generator datapath. It adds several things the fixed 32-bit chirp controller lacks: configurable widths, up/down/triangle modes, clamped no-wrap stepping, a programmable inter-sweep gap, finite or continuous sweep counts, and a start/stop/busy/done control handshake. Configuration is captured on `start`, so register writes during a sweep have no effect.

## Interface
- `W`, 32: NCO control word width (`min_ctrl`, `max_ctrl`, `step`, `nco_ctrl`)
- `RW`, 32: dwell (rate) counter width
- `GW`, 8: gap counter width
- `NW`, 8: sweep count width

- `clk` in 1: sole clock; all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin sweeping (honoured in IDLE only)
- `stop` in 1: abort to IDLE (honoured outside IDLE)
- `mode` in 2: 0 up, 1 down, 2 triangle (up then down), 3 treated as up
- `min_ctrl` in W: lower frequency word
- `max_ctrl` in W: upper frequency word
- `step` in W: increment per dwell; 0 treated as 1
- `div_rate` in RW: dwell length is `div_rate`+1 cycles per value
- `gap` in GW: NCO-reset cycles between sweeps
- `count` in NW: sweeps to run; 0 = continuous
- `nco_ctrl` out W: NCO frequency control word
- `nco_reset` out 1: NCO reset; high in IDLE and GAP
- `busy` out 1: high in SWEEP and GAP
- `sweep_start` out 1: 1-cycle pulse on first cycle of each sweep
- `done` out 1: 1-cycle pulse when the final sweep of a finite run completes
- `err` out 1: 1-cycle pulse when `start` is rejected because `min_ctrl` > `max_ctrl`

## Operation
- States: IDLE, SWEEP, GAP. All outputs are registered.
- Reset values: state IDLE, `nco_ctrl`=0, `nco_reset`=1, `busy`=0, `sweep_start`=0, `done`=0, `err`=0, all counters 0.
- IDLE + `start`:
  - If `min_ctrl` > `max_ctrl`: pulse `err`, stay IDLE.
  - Otherwise: latch `mode`, `min_ctrl`, `max_ctrl`, `step`, `div_rate`, `gap`, `count`; enter SWEEP. `nco_ctrl` = start value (max for down, else min), `nco_reset`=0, `busy`=1, pulse `sweep_start`.
- SWEEP dwell: rate counter runs 0..`div_rate`. At `div_rate` (the tick) it clears and the sweep advances.
- Stepping uses W+1-bit arithmetic, so there is no wrap-around.
  - Up: next = min(nco+step, max).
  - Down: next = max(nco−step, min), computed without underflow.
- Segment end: a tick taken while `nco_ctrl` already equals the segment end value (max going up, min going down).
  - Triangle, up segment: switch to down; `nco_ctrl` = max(max−step, min) on the same tick.
  - Otherwise the sweep is complete: increment the sweep counter.
- Sweep complete:
  - Finite run and sweep counter = `count`: go to IDLE; `nco_ctrl`=0, `nco_reset`=1, `busy`=0, pulse `done`.
  - Else if `gap`=0: restart SWEEP at the start value and pulse `sweep_start`.
  - Else: GAP for exactly `gap` cycles with `nco_reset`=1 and `nco_ctrl` = start value, then SWEEP with `sweep_start` pulse.
- `stop` in SWEEP/GAP: next cycle is IDLE with reset outputs; no `done`. `stop` and `start` together in IDLE: both ignored. `start` while busy: ignored.
- Sweep counter is NW bits and only meaningful for `count`≠0; continuous mode never asserts `done`.

## Timing
- `start` sampled at edge t: outputs take SWEEP values from edge t (1-cycle latency).
- Each value is held `div_rate`+1 cycles.
- Up/down sweep length: K·(`div_rate`+1) cycles, with K = ceil((max−min)/step)+1.
- Triangle sweep length: (K_up + K_down)·(`div_rate`+1), where K_down counts values after max down to min.
- `min_ctrl`=`max_ctrl`: up/down sweep is one dwell; triangle sweep is two dwells.
- `rst` mid-operation returns immediately (asynchronously) to the reset values.

## Test plan
- Up, min=100, max=130, step=10, div=2, count=2, gap=3, `start` at edge 0:
  - `nco_ctrl` 100/110/120/130 for 3 cycles each (edges 0–11).
  - GAP edges 12–14 with `nco_reset`=1.
  - Second sweep edges 15–26.
  - `done` pulse and IDLE at edge 27; `sweep_start` at edges 0 and 15.
- Clamp/no-wrap:
  - Up min=0, max=25, step=10 → 0, 10, 20, 25.
  - Up min=0xFFFFFFF0, max=0xFFFFFFFF, step=0x10 → 0xFFFFFFF0, 0xFFFFFFFF; no wrap to 0.
  - Down min=0, max=5, step=4 → 5, 1, 0.
- Triangle min=0, max=20, step=10, div=0, count=1 → 0, 10, 20, 10, 0 on consecutive cycles, then `done`; `step`=0 yields unit steps.
- `min_ctrl`=9, `max_ctrl`=8 with `start` → `err` pulse, `busy` stays 0.
- Continuous run (`count`=0, gap=0):
  - `start` pulses while busy are ignored.
  - `stop` mid-dwell → next cycle `nco_ctrl`=0, `nco_reset`=1, `busy`=0, no `done`.
  - Async `rst` mid-GAP → all outputs at reset values before the next clock edge.
